// File: rtl/v_hier_drv.sv
// Initiator-side driver for a 4-bit responder: queues commands, drives avec,
// samples qvec after a fixed latency and returns the result on a response stream.
module v_hier_drv #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_data,
    output logic [3:0] avec,
    input  logic [3:0] qvec,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [3:0] rsp_cmd,
    output logic       busy,
    output logic [7:0] txn_cnt
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_lat;
    logic [3:0]    r_avec;
    logic [3:0]    r_rsp_data;
    logic [3:0]    r_rsp_cmd;
    logic          r_rsp_valid;
    logic [7:0]    r_txn;

    logic          w_push;
    logic          w_pop;
    logic          w_sample;
    logic          w_hs;

    assign cmd_ready = (r_count != CW'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    // Pop decision uses the registered count, so a fresh push never bypasses.
    assign w_pop     = (r_state == IDLE) && (r_count != '0);
    assign w_sample  = (r_state == WAIT) && (r_lat == 4'd1);
    assign w_hs      = (r_state == RESP) && rsp_ready;

    assign avec      = r_avec;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_cmd   = r_rsp_cmd;
    assign txn_cnt   = r_txn;
    assign busy      = (r_state != IDLE) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_pop)     w_state_nxt = WAIT;
            WAIT:    if (w_sample)  w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avec      <= '0;
            r_rsp_cmd   <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_lat       <= '0;
            r_txn       <= '0;
        end else begin
            if (w_pop) begin
                r_avec    <= r_mem[r_rptr];
                r_rsp_cmd <= r_mem[r_rptr];
                r_lat     <= 4'(LAT);
            end else if ((r_state == WAIT) && !w_sample) begin
                r_lat <= r_lat - 4'd1;
            end
            if (w_sample) begin
                r_rsp_data  <= qvec;
                r_rsp_valid <= 1'b1;
            end
            if (w_hs) begin
                r_rsp_valid <= 1'b0;
                r_txn       <= r_txn + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_v_hier_drv.sv
// Directed self-checking bench for v_hier_drv (DEPTH=4, LAT=2).
module tb_v_hier_drv;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic [3:0] avec;
    logic [3:0] qvec;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic [3:0] rsp_cmd;
    logic       busy;
    logic [7:0] txn_cnt;

    logic [3:0] qvec_man;
    logic       q_inv;
    int         errors = 0;
    int         checks = 0;

    // Responder stand-in: either a manual value or the inverse of avec.
    assign qvec = q_inv ? ~avec : qvec_man;

    always #5 clk = ~clk;

    v_hier_drv #(.DEPTH(4), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .avec(avec), .qvec(qvec),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cmd(rsp_cmd),
        .busy(busy), .txn_cnt(txn_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_data = 4'h9; rsp_ready = 1'b1;
        q_inv = 1'b0; qvec_man = 4'hF;
        tick(); tick(); tick();
        checks++; if (avec !== 4'h0) begin errors++; $display("FAIL rst_avec: got %h want 0", avec); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (txn_cnt !== 8'd0) begin errors++; $display("FAIL rst_txn: got %0d want 0", txn_cnt); end
        checks++; if ({rsp_data, rsp_cmd} !== 8'h00) begin errors++; $display("FAIL rst_rsp: got %h want 00", {rsp_data, rsp_cmd}); end
        cmd_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_ignored: busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1; qvec_man = 4'hF;
        cmd_valid = 1'b1; cmd_data = 4'hA;
        tick(); // edge 0: push
        cmd_valid = 1'b0;
        checks++; if (avec !== 4'h0) begin errors++; $display("FAIL single_nobypass: avec=%h want 0", avec); end
        tick(); // edge 1: pop
        checks++; if (avec !== 4'hA) begin errors++; $display("FAIL single_avec: got %h want a", avec); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick(); // edge 2
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early: rsp_valid=%b want 0", rsp_valid); end
        qvec_man = 4'h5;
        tick(); // edge 3: sample
        qvec_man = 4'hF;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 4'h5) begin errors++; $display("FAIL single_data: got %h want 5", rsp_data); end
        checks++; if (rsp_cmd !== 4'hA) begin errors++; $display("FAIL single_cmd: got %h want a", rsp_cmd); end
        tick(); // edge 4: handshake
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drop: rsp_valid=%b want 0", rsp_valid); end
        checks++; if (txn_cnt !== 8'd1) begin errors++; $display("FAIL single_txn: got %0d want 1", txn_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_fill();
        rsp_ready = 1'b0; qvec_man = 4'h3;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_data = 4'(i + 1);
            tick();
            checks++;
            if (cmd_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL fill_ready[%0d]: got %b want %b", i, cmd_ready, (i < 4));
            end
        end
        cmd_data = 4'h6; // sixth command held valid
    endtask

    task automatic test_backpressure();
        checks++; if (rsp_valid !== 1'b1 || rsp_cmd !== 4'h1 || rsp_data !== 4'h3) begin
            errors++; $display("FAIL bp_start: valid=%b cmd=%h data=%h want 1 1 3", rsp_valid, rsp_cmd, rsp_data);
        end
        for (int i = 0; i < 10; i++) begin
            qvec_man = 4'(i * 5);
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_cmd !== 4'h1 || rsp_data !== 4'h3 || avec !== 4'h1 || cmd_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b cmd=%h data=%h avec=%h ready=%b want 1 1 3 1 0",
                                   i, rsp_valid, rsp_cmd, rsp_data, avec, cmd_ready);
            end
        end
    endtask

    task automatic test_stall();
        int got;
        rsp_ready = 1'b1;
        tick(); // handshake
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || txn_cnt !== 8'd2) begin
            errors++; $display("FAIL stall_hs: valid=%b ready=%b txn=%0d want 0 0 2", rsp_valid, cmd_ready, txn_cnt);
        end
        tick(); // pop of command 2
        checks++; if (avec !== 4'h2 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL stall_pop: avec=%h ready=%b want 2 1", avec, cmd_ready);
        end
        tick(); // sixth command accepted here
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_accept: ready=%b want 0", cmd_ready); end
        cmd_valid = 1'b0; q_inv = 1'b1;
        got = 0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            tick();
            if (rsp_valid) begin
                checks++;
                if (rsp_cmd !== 4'(got + 2) || rsp_data !== ~4'(got + 2)) begin
                    errors++; $display("FAIL stall_drain[%0d]: cmd=%h data=%h want %h %h", got, rsp_cmd, rsp_data, 4'(got + 2), ~4'(got + 2));
                end
                got++;
            end
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL stall_count: got %0d want 5", got); end
        tick();
        checks++; if (txn_cnt !== 8'd7) begin errors++; $display("FAIL stall_txn: got %0d want 7", txn_cnt); end
    endtask

    task automatic test_order();
        int  idx;
        int  got;
        bit  push_pending;
        idx = 0; got = 0; push_pending = 1'b0; q_inv = 1'b1;
        for (int c = 0; c < 1000 && got < 10; c++) begin
            tick();
            if (push_pending) idx++;
            rsp_ready = 1'($urandom_range(0, 1));
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_cmd !== 4'(got) || rsp_data !== ~4'(got)) begin
                    errors++; $display("FAIL order[%0d]: cmd=%h data=%h want %h %h", got, rsp_cmd, rsp_data, 4'(got), ~4'(got));
                end
                got++;
            end
            cmd_valid = (idx < 10) && ($urandom_range(0, 1) == 1);
            cmd_data = 4'(idx);
            push_pending = cmd_valid && cmd_ready;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        checks++; if (got !== 10) begin errors++; $display("FAIL order_count: got %0d want 10", got); end
        tick(); tick();
        checks++; if (txn_cnt !== 8'd17 || busy !== 1'b0) begin
            errors++; $display("FAIL order_txn: txn=%0d busy=%b want 17 0", txn_cnt, busy);
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int n;
        bit push_pending;
        bit hs_pending;
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        rst_n = 1'b0; #2 rst_n = 1'b1;
        pushed = 0; n = 0; push_pending = 1'b0; hs_pending = 1'b0;
        for (int c = 0; c < 3000 && n < 257; c++) begin
            cmd_valid = (pushed < 257); cmd_data = 4'(pushed);
            push_pending = cmd_valid && cmd_ready;
            hs_pending = rsp_valid && rsp_ready;
            tick();
            if (push_pending) pushed++;
            if (hs_pending) begin
                n++;
                if (n == 255) begin checks++; if (txn_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", txn_cnt); end end
                if (n == 256) begin checks++; if (txn_cnt !== 8'd0) begin errors++; $display("FAIL wrap_256: got %0d want 0", txn_cnt); end end
                if (n == 257) begin checks++; if (txn_cnt !== 8'd1) begin errors++; $display("FAIL wrap_257: got %0d want 1", txn_cnt); end end
            end
        end
        cmd_valid = 1'b0;
        checks++; if (n !== 257) begin errors++; $display("FAIL wrap_count: got %0d want 257", n); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        tick(); tick();
        rsp_ready = 1'b0; q_inv = 1'b0; qvec_man = 4'h0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_data = 4'(i + 8);
            tick();
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        tick(); // handshake of 0x8
        tick(); // pop of 0x9, three left queued
        checks++; if (avec !== 4'h9 || busy !== 1'b1) begin errors++; $display("FAIL mid_setup: avec=%h busy=%b want 9 1", avec, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (avec !== 4'h0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL mid_async: avec=%h valid=%b busy=%b ready=%b want 0 0 0 1", avec, rsp_valid, busy, cmd_ready);
        end
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_quiet: activity=%b want 0", seen); end
        cmd_valid = 1'b1; cmd_data = 4'h7;
        tick();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1 || rsp_cmd !== 4'h7) begin
            errors++; $display("FAIL mid_new: seen=%b cmd=%h want 1 7", seen, rsp_cmd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_stall();
        test_order();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/v_hier_drv.md
Name: v_hier_drv

Overview:
- Initiator-side driver for a v_hier_sub-style 4-bit responder: drives `avec` and samples the returned `qvec`.
- Accepts 4-bit commands over a valid/ready stream and buffers them in a small FIFO.
- Issues one command at a time on `avec`, waits a fixed response latency, samples `qvec`, and returns the result on a valid/ready response stream.
- Sits one hierarchy level above the responder, in the same test hierarchy.

Parameters:
- DEPTH, 4, command FIFO depth; power of 2, minimum 2.
- LAT, 2, cycles from `avec` update to `qvec` sample; minimum 1, maximum 15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_data  input  4  command value to drive onto `avec`.
- avec  output  4  registered drive toward the responder.
- qvec  input  4  responder output; sampled once per transaction.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  4  sampled `qvec`.
- rsp_cmd  output  4  command that produced this response.
- busy  output  1  high when state != IDLE or the FIFO is non-empty.
- txn_cnt  output  8  completed response handshakes; wraps 255 -> 0.

Behaviour:
- Reset (`rst_n` low, asynchronous): `avec`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_cmd`=0, `txn_cnt`=0, FIFO empty, state IDLE, latency counter 0.
  - `cmd_ready`=1 and `busy`=0 while in reset.
  - Commands presented during reset are ignored.
- Reset mid-operation aborts immediately: queued commands and any pending response are discarded, and `avec` returns to 0.
- FIFO:
  - `cmd_ready` = !full, combinational from the registered count.
  - Push on an edge where `cmd_valid && cmd_ready`.
  - Count width is clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
  - No bypass: a command pushed at edge P pops at edge P+1 at the earliest.
  - Push and pop on the same edge are allowed when not full; the count is unchanged.
  - When full, `cmd_ready`=0 and the command stalls with no loss.
- State machine IDLE / WAIT / RESP:
  - IDLE: if FIFO count != 0 at edge E0, pop the head. `avec` <= head and `rsp_cmd` <= head; counter <= LAT; go to WAIT. Otherwise stay in IDLE.
  - WAIT: if counter == 1, then `rsp_data` <= `qvec`, `rsp_valid` <= 1, go to RESP. Otherwise decrement the counter. This samples `qvec` at edge E0+LAT.
  - RESP: hold `rsp_valid`, `rsp_data` and `rsp_cmd` stable until `rsp_ready`. On the handshake edge: `rsp_valid` <= 0, `txn_cnt` <= `txn_cnt`+1 (mod 256), go to IDLE.
- `avec` holds its last driven value between transactions; it changes only on a pop or on reset.
- `qvec` is ignored at all edges other than the sample edge.
- Throughput with `rsp_ready` tied high: one transaction per LAT+2 cycles.
- `rsp_valid` never asserts without a prior pop. Responses leave in FIFO push order.

Test Plan:
- LAT=2, single command 0xA at edge 0 with `rsp_ready`=1:
  - required: `avec`=0xA after edge 1;
  - `qvec` is set to 0x5 only during the cycle before edge 3, and to 0xF otherwise;
  - `rsp_valid` rises after edge 3 with `rsp_data`=0x5 and `rsp_cmd`=0xA;
  - handshake at edge 4; `txn_cnt`=1; `busy`=0 after edge 4.
- `rsp_ready`=0, push 5 commands back-to-back:
  - required: first pops; 4 more are accepted; `cmd_ready` goes low after the FIFO fills;
  - the 6th command stalls with `cmd_valid` held and is accepted exactly one cycle after the next pop.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP while `qvec` toggles.
  - required: `rsp_valid`, `rsp_data` and `rsp_cmd` stay constant; no further pop occurs; `avec` is unchanged.
- Ordering / pointer wrap: stream commands 0..9 with random `cmd_valid` and `rsp_ready`; `qvec` = ~`avec`.
  - required: `rsp_cmd` sequence is 0..9 and `rsp_data` = ~`rsp_cmd` for every response.
- Counter wrap: complete 257 transactions.
  - required: `txn_cnt` reads 255 after the 255th, 0 after the 256th, and 1 after the 257th.
- Reset mid-WAIT with 3 commands queued: drop `rst_n` asynchronously between edges.
  - required: `avec`=0, `rsp_valid`=0, `busy`=0, `cmd_ready`=1 immediately;
  - after release, no response appears until a new command is pushed.
